// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART RX oversample counter.
// Frame length, bit mid-point and 3-sample majority vote.
package uart_rx_pkg;

    localparam int unsigned PRESC_W_DEF   = 6;
    localparam int unsigned BIT_CNT_W_DEF = 4;
    localparam int unsigned MIN_PRESC_DEF = 5;

    // start + data + parity + stop(s)
    function automatic int unsigned frame_len(
        input logic [3:0] dl,
        input logic       par,
        input logic       s2
    );
        return 32'd2 + 32'(dl) + 32'(par) + 32'(s2);
    endfunction

    function automatic int unsigned mid_point(input int unsigned p);
        return p >> 1;
    endfunction

    function automatic logic maj3(input logic [2:0] s);
        return (s[2] & s[1]) | (s[2] & s[0]) | (s[1] & s[0]);
    endfunction

endpackage

// File: rtl/uart_rx_majority_sampler.sv
// Captures three samples around the bit centre and registers their majority.
// Ports: clk_i, rst_i, en_i, rx_i, edge_i, mid_i -> valid_o, bit_o.
module uart_rx_majority_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               rx_i,
    input  logic [PRESC_W-1:0] edge_i,
    input  logic [PRESC_W-1:0] mid_i,
    output logic               valid_o,
    output logic               bit_o
);

    logic [2:0]         sh_q;
    logic [2:0]         sh_d;
    logic               valid_q;
    logic               bit_q;
    logic [PRESC_W-1:0] lo;
    logic [PRESC_W-1:0] hi;
    logic               hit;
    logic               vote;

    assign lo   = mid_i - PRESC_W'(1);
    assign hi   = mid_i + PRESC_W'(1);
    assign hit  = en_i & ((edge_i == lo) | (edge_i == mid_i) | (edge_i == hi));
    // The third capture and the vote register on the same edge,
    // so the vote uses the shift value that includes this sample.
    assign vote = en_i & (edge_i == hi);
    assign sh_d = {sh_q[1:0], rx_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q    <= 3'b111;
            valid_q <= 1'b0;
            bit_q   <= 1'b1;
        end else begin
            valid_q <= vote;
            if (!en_i) begin
                sh_q <= 3'b111;
            end else if (hit) begin
                sh_q <= sh_d;
            end
            if (vote) begin
                bit_q <= maj3(sh_d);
            end
        end
    end

    assign valid_o = valid_q;
    assign bit_o   = bit_q;

endmodule

// File: rtl/uart_rx_oversample_counter.sv
// UART RX edge/bit counter with config latch, centred sampling and frame pulse.
// Ports: CLK, Reset, count_EN, RX_IN, frame config -> counters, strobes.
module uart_rx_oversample_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W   = PRESC_W_DEF,
    parameter int BIT_CNT_W = BIT_CNT_W_DEF,
    parameter int MIN_PRESC = MIN_PRESC_DEF
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 count_EN,
    input  logic                 RX_IN,
    input  logic [PRESC_W-1:0]   Prescale,
    input  logic [3:0]           data_len,
    input  logic                 parity_en,
    input  logic                 stop_2,
    output logic [BIT_CNT_W-1:0] bit_count,
    output logic [PRESC_W-1:0]   edge_count,
    output logic                 Last_edge,
    output logic                 sample_valid,
    output logic                 sampled_bit,
    output logic                 frame_done
);

    logic                 en_q;
    logic                 first;
    logic [PRESC_W-1:0]   p_q;
    logic [PRESC_W-1:0]   mid_q;
    logic [BIT_CNT_W-1:0] fb_q;
    logic [PRESC_W-1:0]   p_live;
    logic [PRESC_W-1:0]   mid_live;
    logic [BIT_CNT_W-1:0] fb_live;
    logic [PRESC_W-1:0]   p_cur;
    logic [PRESC_W-1:0]   mid_cur;
    logic [BIT_CNT_W-1:0] fb_cur;
    logic [PRESC_W-1:0]   edge_q;
    logic [PRESC_W-1:0]   edge_d;
    logic [BIT_CNT_W-1:0] bit_q;
    logic [BIT_CNT_W-1:0] bit_d;
    logic                 done_q;
    logic                 done_d;

    assign first    = count_EN & ~en_q;
    assign p_live   = (Prescale < PRESC_W'(MIN_PRESC)) ?
                      PRESC_W'(MIN_PRESC) : Prescale;
    assign mid_live = PRESC_W'(mid_point(32'(p_live)));
    assign fb_live  = BIT_CNT_W'(frame_len(data_len, parity_en, stop_2));

    // On the latch cycle the registers are not yet loaded,
    // so decode from the live values being captured.
    assign p_cur   = first ? p_live   : p_q;
    assign mid_cur = first ? mid_live : mid_q;
    assign fb_cur  = first ? fb_live  : fb_q;

    assign Last_edge = (edge_q == p_cur);

    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        done_d = 1'b0;
        if (!count_EN) begin
            edge_d = PRESC_W'(1);
            bit_d  = '0;
        end else if (Last_edge) begin
            edge_d = PRESC_W'(1);
            if (bit_q == fb_cur - BIT_CNT_W'(1)) begin
                bit_d  = '0;
                done_d = 1'b1;
            end else begin
                bit_d = bit_q + BIT_CNT_W'(1);
            end
        end else begin
            edge_d = edge_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            en_q   <= 1'b0;
            p_q    <= '0;
            mid_q  <= '0;
            fb_q   <= '0;
            edge_q <= PRESC_W'(1);
            bit_q  <= '0;
            done_q <= 1'b0;
        end else begin
            en_q <= count_EN;
            if (first) begin
                p_q   <= p_live;
                mid_q <= mid_live;
                fb_q  <= fb_live;
            end
            edge_q <= edge_d;
            bit_q  <= bit_d;
            done_q <= done_d;
        end
    end

    uart_rx_majority_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .clk_i   (CLK),
        .rst_i   (Reset),
        .en_i    (count_EN),
        .rx_i    (RX_IN),
        .edge_i  (edge_q),
        .mid_i   (mid_cur),
        .valid_o (sample_valid),
        .bit_o   (sampled_bit)
    );

    assign bit_count  = bit_q;
    assign edge_count = edge_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_rx_oversample_counter.sv
// Directed bench for uart_rx_oversample_counter with a vote scoreboard.
// Drives frames, checks counters per cycle and votes via a queue.
module tb_uart_rx_oversample_counter;

    logic       CLK;
    logic       Reset;
    logic       count_EN;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic [3:0] data_len;
    logic       parity_en;
    logic       stop_2;
    logic [3:0] bit_count;
    logic [5:0] edge_count;
    logic       Last_edge;
    logic       sample_valid;
    logic       sampled_bit;
    logic       frame_done;

    int         n_cmp = 0;
    int         n_err = 0;
    logic       exp_q[$];
    logic       ev;

    int          cP, cFB, cMid, cyc, gb, ge;
    logic [15:0] rx_bits;
    logic [2:0]  smp;

    uart_rx_oversample_counter dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .count_EN     (count_EN),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .data_len     (data_len),
        .parity_en    (parity_en),
        .stop_2       (stop_2),
        .bit_count    (bit_count),
        .edge_count   (edge_count),
        .Last_edge    (Last_edge),
        .sample_valid (sample_valid),
        .sampled_bit  (sampled_bit),
        .frame_done   (frame_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic maj(input logic [2:0] s);
        return (int'(s[0]) + int'(s[1]) + int'(s[2])) >= 2;
    endfunction

    // Vote scoreboard: pop one expectation per sample_valid pulse.
    always @(posedge CLK) begin
        #1;
        if (sample_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sv_unexpected", 32'(sample_valid), 0);
            end else begin
                ev = exp_q.pop_front();
                check("sampled_bit", 32'(sampled_bit), 32'(ev));
            end
        end
        check("no_overlap", 32'(sample_valid & frame_done), 0);
    end

    task automatic restart(input int p, input int p_eff, input logic [3:0] dl,
                           input logic par, input logic s2, input int fb,
                           input logic [15:0] bits);
        count_EN = 1'b0;
        tick();
        Prescale  = 6'(p);
        data_len  = dl;
        parity_en = par;
        stop_2    = s2;
        rx_bits   = bits;
        gb        = -1;
        ge        = 0;
        cP        = p_eff;
        cFB       = fb;
        cMid      = p_eff / 2;
        cyc       = 1;
        smp       = 3'b111;
        count_EN  = 1'b1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            int   b;
            int   e;
            logic rx;
            b  = (cyc - 1) / cP;
            e  = (cyc - 1) % cP + 1;
            rx = rx_bits[b % cFB] ^ ((b == gb) && (e == ge));
            RX_IN = rx;
            check("edge", 32'(edge_count), e);
            check("bit", 32'(bit_count), b % cFB);
            check("last", 32'(Last_edge), 32'(e == cP));
            check("valid", 32'(sample_valid), 32'(e == cMid + 2));
            check("done", 32'(frame_done),
                  32'(cyc > 1 && (cyc - 1) % (cP * cFB) == 0));
            if (e >= cMid - 1 && e <= cMid + 1) smp = {smp[1:0], rx};
            if (e == cMid + 1) exp_q.push_back(maj(smp));
            tick();
            cyc++;
        end
    endtask

    initial begin
        Reset     = 1'b1;
        count_EN  = 1'b0;
        RX_IN     = 1'b1;
        Prescale  = 6'd8;
        data_len  = 4'd8;
        parity_en = 1'b0;
        stop_2    = 1'b0;
        tick();
        check("rst_bit", 32'(bit_count), 0);
        check("rst_edge", 32'(edge_count), 1);
        check("rst_sv", 32'(sample_valid), 0);
        check("rst_sb", 32'(sampled_bit), 1);
        check("rst_fd", 32'(frame_done), 0);
        check("rst_last", 32'(Last_edge), 0);
        Reset = 1'b0;
        tick();

        // P=8, 8N1, bit 0 low: frame_done 80 enabled cycles in.
        restart(8, 8, 4'd8, 1'b0, 1'b0, 10, 16'hFFFE);
        run(81);

        // P=16 with a single-cycle glitch at edge 8 of a low bit.
        restart(16, 16, 4'd8, 1'b0, 1'b0, 10, 16'hFFFE);
        gb = 0;
        ge = 8;
        run(32);

        // Prescale=3 clamps to 5; samples at edges 1,2,3.
        restart(3, 5, 4'd5, 1'b0, 1'b0, 7, 16'hAAAA);
        run(36);

        // 9 data + parity + 2 stop at P=5; mid-frame config change ignored.
        restart(5, 5, 4'd9, 1'b1, 1'b1, 13, 16'h1234);
        run(10);
        Prescale = 6'd16;
        data_len = 4'd5;
        run(56);

        // count_EN falls on the last edge of bit 4.
        restart(8, 8, 4'd8, 1'b0, 1'b0, 10, 16'h0155);
        run(39);
        check("drop_last", 32'(Last_edge), 1);
        check("drop_bit4", 32'(bit_count), 4);
        count_EN = 1'b0;
        tick();
        check("drop_bit", 32'(bit_count), 0);
        check("drop_edge", 32'(edge_count), 1);
        check("drop_fd", 32'(frame_done), 0);
        check("drop_sv", 32'(sample_valid), 0);

        // count_EN falls on the last edge of the last bit: no frame_done.
        restart(5, 5, 4'd5, 1'b0, 1'b0, 7, 16'h0055);
        run(34);
        check("end_last", 32'(Last_edge), 1);
        check("end_bit", 32'(bit_count), 6);
        count_EN = 1'b0;
        tick();
        check("end_fd", 32'(frame_done), 0);
        check("end_bit0", 32'(bit_count), 0);
        check("end_edge", 32'(edge_count), 1);
        tick();
        check("end_fd2", 32'(frame_done), 0);

        // Reset in the vote cycle.
        restart(8, 8, 4'd8, 1'b0, 1'b0, 10, 16'hFFFE);
        run(5);
        check("vote_sv", 32'(sample_valid), 1);
        check("vote_sb", 32'(sampled_bit), 0);
        Reset = 1'b1;
        tick();
        check("mrst_bit", 32'(bit_count), 0);
        check("mrst_edge", 32'(edge_count), 1);
        check("mrst_sv", 32'(sample_valid), 0);
        check("mrst_sb", 32'(sampled_bit), 1);
        check("mrst_fd", 32'(frame_done), 0);
        Reset    = 1'b0;
        count_EN = 1'b0;
        tick();
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
